// File: rtl/diff_maccum_pkg.sv
// diff_maccum_pkg
//   Shared definitions for the DiffMaccum weight path. The synapse core and
//   the accumulator both use them:
//   - state_e         : accumulator FSM states (collecting / result held)
//   - sub_width()     : width of the sub field; 2 for "rc" networks, else 1
//   - ctrl_*_pos()    : bit positions inside the control field {leap, lst, sub}
//   - ctrl_width()    : total control field width
package diff_maccum_pkg;

  typedef enum logic [0:0] {
    StAccum = 1'b0,
    StEmit  = 1'b1
  } state_e;

  // Bit 0 of sub is always "negate". Bit 1 ("double") exists only for rc.
  localparam int unsigned CtrlSubLsb = 0;

  function automatic int unsigned sub_width(input bit is_rc);
    return is_rc ? 2 : 1;
  endfunction

  // The control field sits above the weights: {leap, lst, sub[sw-1:0]}.
  function automatic int unsigned ctrl_lst_pos(input int unsigned sw);
    return sw;
  endfunction

  function automatic int unsigned ctrl_leap_pos(input int unsigned sw);
    return sw + 1;
  endfunction

  function automatic int unsigned ctrl_width(input int unsigned sw);
    return sw + 2;
  endfunction

endpackage

// File: rtl/diff_maccum_accum_sat_add.sv
// diff_maccum_accum_sat_add
//   Purely combinational per-column step: res = sat(sum + term), where term
//   is the sign-extended weight, optionally negated (sub[0]) and doubled
//   (sub[1], rc only), or zero on a leap beat. The add is done at AW+2 bits
//   so the widest term plus any in-range sum cannot wrap before the clamp.
// Ports:
//   sum_i  [AW-1:0] current signed accumulator value
//   w_i    [WD-1:0] signed weight for this column
//   sub_i  [SW-1:0] {double (rc only), negate}
//   leap_i          forces the term to zero
//   res_o  [AW-1:0] saturated sum
module diff_maccum_accum_sat_add
  import diff_maccum_pkg::*;
#(
  parameter int unsigned WD   = 4,
  parameter int unsigned AW   = 12,
  parameter bit          IsRc = 1'b1,
  parameter int unsigned SW   = sub_width(IsRc)
) (
  input  logic [AW-1:0] sum_i,
  input  logic [WD-1:0] w_i,
  input  logic [SW-1:0] sub_i,
  input  logic          leap_i,
  output logic [AW-1:0] res_o
);

  localparam int unsigned EW = AW + 2;

  localparam logic signed [EW-1:0] MaxV = {3'b000, {(AW - 1){1'b1}}};
  localparam logic signed [EW-1:0] MinV = {3'b111, {(AW - 1){1'b0}}};

  logic                 dbl;
  logic signed [EW-1:0] w_ext;
  logic signed [EW-1:0] term;
  logic signed [EW-1:0] sum_ext;
  logic signed [EW-1:0] total;

  if (IsRc) begin : g_rc
    assign dbl = sub_i[SW-1];
  end else begin : g_plain
    assign dbl = 1'b0;
  end

  always_comb begin
    w_ext   = {{(EW - WD){w_i[WD-1]}}, w_i};
    term    = sub_i[CtrlSubLsb] ? -w_ext : w_ext;
    if (dbl) begin
      term = term <<< 1;
    end
    if (leap_i) begin
      term = '0;
    end
    sum_ext = {{2{sum_i[AW-1]}}, sum_i};
    total   = sum_ext + term;
    if (total > MaxV) begin
      res_o = MaxV[AW-1:0];
    end else if (total < MinV) begin
      res_o = MinV[AW-1:0];
    end else begin
      res_o = total[AW-1:0];
    end
  end

endmodule

// File: rtl/diff_maccum_accum.sv
// diff_maccum_accum
//   Consumer end of the synapse weight stream. Accepts weight-row beats
//   {leap, lst, sub, w} and accumulates them into NB signed saturating
//   accumulators. On the last beat of a frame the saturated sums are loaded
//   into the output register, the accumulators clear, and the result is
//   presented on the RS handshake.
// Ports:
//   iCLK, iRST            clock, asynchronous active-high reset
//   iValid_BS / oReady_BS weight beat handshake
//   iData_BS              {leap, lst, sub[SW-1:0], w[NB*WD-1:0]}
//   oValid_RS / iReady_RS result handshake
//   oData_RS              NB sums, column j at [j*AW +: AW]
module diff_maccum_accum
  import diff_maccum_pkg::*;
#(
  parameter int unsigned NB   = 4,
  parameter int unsigned WD   = 4,
  parameter int unsigned AW   = 12,
  parameter string       TYPE = "rc",
  localparam bit          IsRc = (TYPE == "rc"),
  localparam int unsigned SW   = sub_width(IsRc),
  localparam int unsigned DW   = ctrl_width(SW) + NB * WD
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid_BS,
  output logic             oReady_BS,
  input  logic [DW-1:0]    iData_BS,
  output logic             oValid_RS,
  input  logic             iReady_RS,
  output logic [NB*AW-1:0] oData_RS
);

  localparam int unsigned CW = ctrl_width(SW);

  state_e             state_q, state_d;
  logic [AW-1:0]      acc_q [NB];
  logic [AW-1:0]      acc_d [NB];
  logic [AW-1:0]      sat_res [NB];
  logic [NB*AW-1:0]   out_q, out_d;

  logic [CW-1:0]      ctrl;
  logic [NB*WD-1:0]   beat_w;
  logic [SW-1:0]      beat_sub;
  logic               beat_lst;
  logic               beat_leap;
  logic               beat_acc;

  assign ctrl      = iData_BS[DW-1 -: CW];
  assign beat_w    = iData_BS[NB*WD-1:0];
  assign beat_sub  = ctrl[CtrlSubLsb +: SW];
  assign beat_lst  = ctrl[ctrl_lst_pos(SW)];
  assign beat_leap = ctrl[ctrl_leap_pos(SW)];

  // While a result is held, a new beat may only enter if the result leaves
  // in the same cycle; this keeps a lst beat from overwriting an untaken sum.
  assign oReady_BS = (state_q == StAccum) | iReady_RS;
  assign beat_acc  = iValid_BS & oReady_BS;

  assign oValid_RS = (state_q == StEmit);
  assign oData_RS  = out_q;

  for (genvar j = 0; j < NB; j++) begin : g_col
    diff_maccum_accum_sat_add #(
      .WD   (WD),
      .AW   (AW),
      .IsRc (IsRc),
      .SW   (SW)
    ) u_sat_add (
      .sum_i  (acc_q[j]),
      .w_i    (beat_w[j*WD +: WD]),
      .sub_i  (beat_sub),
      .leap_i (beat_leap),
      .res_o  (sat_res[j])
    );
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    acc_d   = acc_q;
    if (beat_acc) begin
      if (beat_lst) begin
        // Frame closes: capture the final sums and start the next frame clean.
        for (int j = 0; j < NB; j++) begin
          out_d[j*AW +: AW] = sat_res[j];
          acc_d[j]          = '0;
        end
        state_d = StEmit;
      end else begin
        acc_d   = sat_res;
        state_d = StAccum;
      end
    end else if ((state_q == StEmit) && iReady_RS) begin
      state_d = StAccum;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= StAccum;
      out_q   <= '0;
      for (int j = 0; j < NB; j++) begin
        acc_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      for (int j = 0; j < NB; j++) begin
        acc_q[j] <= acc_d[j];
      end
    end
  end

endmodule

// File: doc/diff_maccum_accum.md
# diff_maccum_accum

Consumer end of the synapse weight stream: accepts weight-row beats `{leap, lst, sub, weights}` from the synapse core's B-side handshake and accumulates them into NB signed saturating accumulators. On the last beat of a frame, it emits the NB accumulated sums on a result handshake and clears for the next frame. It sits between the synapse core and the neuron activation stage inside the DiffMaccum network.

## Interface
- `NB`, 4: number of columns / accumulators per beat
- `WD`, 4: signed weight width per column
- `AW`, 12: signed accumulator width (AW > WD+1)
- `TYPE`, "rc": "rc" gives a 2-bit sub field; any other value gives a 1-bit sub field (SW = 2 or 1)

Ports:
- `iCLK` in 1: clock
- `iRST` in 1: reset; asynchronous and active-high, one clock domain
- `iValid_BS` in 1: weight beat valid
- `oReady_BS` out 1: weight beat accepted this cycle when high together with `iValid_BS`
- `iData_BS` in 2+SW+NB*WD: `{leap, lst, sub[SW-1:0], w[NB*WD-1:0]}`; column j is `w[j*WD +: WD]`, two's complement
- `oValid_RS` out 1: result valid
- `iReady_RS` in 1: result consumer ready
- `oData_RS` out NB*AW: sums; column j is `oData_RS[j*AW +: AW]`

## Operation
- Two states: ACCUM (collecting) and EMIT (result held).
- Accept condition: `acc = iValid_BS && oReady_BS`.
  - `oReady_BS = 1` in ACCUM.
  - `oReady_BS = iReady_RS` in EMIT.
- Per accepted beat, per column j:
  - term = sign-extend(w_j) to AW.
  - If sub[0]=1, term is negated.
  - If TYPE=="rc" and sub[1]=1, term is shifted left by 1.
  - If leap=1, term is 0 and only the control bits act.
- Accumulation is `sum_j <= sat(sum_j + term)`. Saturation clamps to [-2^(AW-1), 2^(AW-1)-1]. The clamp is computed at AW+2 bits, and the result stays clamped until the frame clears.
- Accepted beat with lst=0: update the accumulators and stay in ACCUM.
- Accepted beat with lst=1:
  - Load the output register with sat(sum + term) for each column.
  - Clear the accumulators to 0.
  - Go to EMIT.
- In EMIT with `iReady_RS=1`, the result is taken (`oValid_RS` drops) and state returns to ACCUM. The exception is when the same-cycle accepted beat has lst=1; then the output register reloads and the block stays in EMIT.
- A beat accepted in the EMIT→ACCUM cycle with lst=0 accumulates into the cleared accumulators. No bubble is inserted.
- A frame consisting of a single lst=1 beat is legal. It emits just that beat's terms.
- A leap beat with lst=1 emits the current sums unchanged.

## Timing
- Reset values (asynchronous):
  - state = ACCUM
  - `oValid_RS = 0`
  - `oData_RS = 0`
  - all accumulators = 0
  - `oReady_BS` follows state, so it is 1 after reset
- Latency: the result is valid the cycle after the lst beat is accepted.
- Sustained throughput is one beat per cycle while `iReady_RS` stays high.
- `oData_RS` is stable while `oValid_RS=1 && !iReady_RS`. `oValid_RS` never drops without a handshake.
- `oReady_BS` is combinational from `iReady_RS` in EMIT. It does not depend combinationally on `iValid_BS`.
- Reset asserted mid-frame discards partial sums and any pending result. The first beat after release starts a new frame.

## Structure
- Shared package `diff_maccum_pkg`:
  - state encoding (ACCUM, EMIT)
  - the SW function of TYPE
  - control field bit positions `{leap, lst, sub}`, which are also used by the synapse core
- Sub-module `sat_add`, instantiated NB times via generate. Inputs: AW-bit sum, WD-bit weight, sub bits, leap. Output: the saturated AW-bit result. It is purely combinational.

## Test plan
- NB=4, WD=4, AW=12, rc; beats w={1,2,3,4} lst=0, then {1,1,1,1} lst=1, with `iReady_RS=1` → one cycle later oValid=1, sums {2,3,4,5}, then ACCUM.
- Same frame with sub=01 on the 2nd beat and sub=10 on a 3rd beat w={-8,…} lst=1 → column 0 = 1-1-16 = -16. Check negate, shift and sign-extend.
- 300 beats of w=7 sub=10 lst=0, then a leap lst=1 beat → all sums saturate at 2047. A following frame of a single beat w=-1 lst=1 → emits -1, confirming the clear.
- Hold `iReady_RS=0` for 5 cycles after the lst beat with `iValid_BS=1` → `oReady_BS=0`, `oData_RS` stable, no beat consumed. Release → the result and the next beat complete in the same cycle.
- Back-to-back single-beat lst=1 frames with `iReady_RS=1` → one result per cycle, each equal to its own beat.
- Assert `iRST` mid-frame after 2 beats → outputs and sums are 0 immediately. Next frame {3,3,3,3} lst=1 → emits {3,3,3,3}.
